fifo_rd_burst_ctrl: RTL and testbench

Read-side sequencer for the async_fifo, running in the read clock domain. Issues read_req only when the FIFO is non-empty and buffer space is guaranteed, absorbs the FIFO read latency in an internal skid buffer, and presents words downstream on a valid/ready stream grouped into fixed-length bursts marked with m_last. Sits between the async_fifo read port and the phase-noise sample packetizer.

---
 rtl/fifo_rd_burst_ctrl.sv | 153 +++++++++++++++
 tb/tb_fifo_rd_burst_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_burst_ctrl.sv
// Read-side burst sequencer for async_fifo: credit-gated reads, skid buffer, valid/ready bursts.
// Optional statistics counters (word_cnt, stall_cnt) are enabled with `define FIFO_RD_STATS_EN.
module fifo_rd_burst_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  read_req,
  input  logic                  data_out_vld,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  flush_done,
  output logic                  rd_err
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]           word_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(SKID_DEPTH);
  localparam int unsigned CW = $clog2(SKID_DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned PW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  if ((SKID_DEPTH < RD_LATENCY + 1) || (BURST_LEN < 1) ||
      ((SKID_DEPTH & (SKID_DEPTH - 1)) != 0)) begin : g_cfg_err
    $error("fifo_rd_burst_ctrl: invalid BURST_LEN/RD_LATENCY/SKID_DEPTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         outst, outst_nxt, occ, occ_nxt, occ_pop;
  logic [AW-1:0]         rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt;
  logic [PW-1:0]         pos, pos_nxt;
  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] m_data_nxt;
  logic                  pop, push, stray, drained;
  logic                  m_valid_nxt, m_last_nxt, busy_nxt, flush_done_nxt;

  // Next-state, credit and head-of-buffer selection; registered outputs are
  // computed from next-cycle values so they equal their definitions each cycle.
  always_comb begin
    state_nxt      = state;
    pop            = m_valid && m_ready;
    push           = data_out_vld && (outst != '0);
    stray          = data_out_vld && (outst == '0);
    occ_pop        = occ - CW'(pop);
    read_req       = (state == RUN) && !fifo_empty &&
                     ((SW'(outst) + SW'(occ_pop)) < SW'(SKID_DEPTH));
    outst_nxt      = outst + CW'(read_req) - CW'(push);
    occ_nxt        = occ_pop + CW'(push);
    rd_ptr_nxt     = rd_ptr + AW'(pop);
    wr_ptr_nxt     = wr_ptr + AW'(push);
    drained        = (outst == '0) && (occ == '0);
    pos_nxt        = pos;
    m_data_nxt     = m_data;
    m_valid_nxt    = 1'b0;
    m_last_nxt     = 1'b0;
    busy_nxt       = 1'b0;
    flush_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (flush)       state_nxt = FLUSH;
        else if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (flush)        state_nxt = FLUSH;
        else if (!enable) state_nxt = IDLE;
      end
      FLUSH: begin
        if (drained) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if ((state == FLUSH) && drained) pos_nxt = '0;
    else if (pop)                    pos_nxt = m_last ? '0 : pos + PW'(1);

    m_valid_nxt = (occ_nxt != '0);
    // A word pushed into a buffer that empties this cycle bypasses the array.
    if (push && (occ_pop == '0)) m_data_nxt = data_out;
    else if (occ_nxt != '0)      m_data_nxt = mem[rd_ptr_nxt];

    m_last_nxt     = m_valid_nxt &&
                     ((pos_nxt == PW'(BURST_LEN - 1)) ||
                      ((state_nxt == FLUSH) && (outst_nxt == '0) && (occ_nxt == CW'(1))));
    busy_nxt       = (state_nxt != IDLE) || (outst_nxt != '0) || (occ_nxt != '0);
    flush_done_nxt = (state_nxt == FLUSH) && (outst_nxt == '0) && (occ_nxt == '0);
  end

  always_ff @(posedge rd_clk) begin
    if (push) mem[wr_ptr] <= data_out;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      outst      <= '0;
      occ        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      pos        <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      flush_done <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      outst      <= outst_nxt;
      occ        <= occ_nxt;
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      pos        <= pos_nxt;
      m_data     <= m_data_nxt;
      m_valid    <= m_valid_nxt;
      m_last     <= m_last_nxt;
      busy       <= busy_nxt;
      flush_done <= flush_done_nxt;
      rd_err     <= rd_err | stray;
    end
  end

`ifdef FIFO_RD_STATS_EN
  // Saturating observation counters.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && (word_cnt != '1))
        word_cnt <= word_cnt + 32'd1;
      if (m_valid && !m_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_burst_ctrl.sv
// Directed self-checking bench for fifo_rd_burst_ctrl with a behavioural FIFO read-port model.
module tb_fifo_rd_burst_ctrl;

  logic        rd_clk = 1'b0;
  logic        rst_n, enable, flush, fifo_empty, read_req, data_out_vld;
  logic [31:0] data_out, m_data;
  logic        m_valid, m_ready, m_last, busy, flush_done, rd_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] fq[$];      // words held by the FIFO model
  logic [31:0] pq[$];      // words in flight inside the FIFO model
  int          pdue[$];
  logic [32:0] got[$];     // accepted {m_last, m_data}
  int          acc_cyc[$];
  int          cyc_n = 0;
  int          lat = 1;
  int          reads = 0;
  int          rr_empty_viol = 0;
  int          fd_cnt = 0;
  int          fd_cyc = -1;
  int          base, t, unstable;
  logic [31:0] lm;

  fifo_rd_burst_ctrl dut (
    .rd_clk       (rd_clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .read_req     (read_req),
    .data_out_vld (data_out_vld),
    .data_out     (data_out),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .busy         (busy),
    .flush_done   (flush_done),
    .rd_err       (rd_err)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just before the rising edge, then drive the next cycle at the falling edge.
  task automatic cyc();
    logic rr;
    #1;
    rr = read_req;
    if (read_req && fifo_empty) rr_empty_viol++;
    if (m_valid && m_ready) begin
      got.push_back({m_last, m_data});
      acc_cyc.push_back(cyc_n);
    end
    if (flush_done) begin
      fd_cnt++;
      fd_cyc = cyc_n;
    end
    @(negedge rd_clk);
    if (rr && (fq.size() > 0)) begin
      pq.push_back(fq.pop_front());
      pdue.push_back(cyc_n + lat);
      reads++;
    end
    cyc_n++;
    data_out_vld = 1'b0;
    if ((pdue.size() > 0) && (pdue[0] == cyc_n)) begin
      data_out     = pq.pop_front();
      data_out_vld = 1'b1;
      void'(pdue.pop_front());
    end
    fifo_empty = (fq.size() == 0);
    flush      = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load(input int n);
    for (int i = 1; i <= n; i++) fq.push_back(32'(i));
    fifo_empty = 1'b0;
  endtask

  task automatic last_mask();
    lm = '0;
    for (int i = 0; i < got.size() && i < 32; i++) lm[i] = got[i][32];
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; fifo_empty = 1'b1;
    data_out_vld = 1'b0; data_out = '0; m_ready = 1'b0;
    repeat (2) @(negedge rd_clk);
    #1;
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_last", 32'(m_last), 32'd0);
    check_eq("rst_m_data", m_data, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_flush_done", 32'(flush_done), 32'd0);
    check_eq("rst_rd_err", 32'(rd_err), 32'd0);
    check_eq("rst_read_req", 32'(read_req), 32'd0);
    @(negedge rd_clk);
    rst_n = 1'b1;

    // Basic burst
    load(4); enable = 1'b1; m_ready = 1'b1;
    run(12);
    check_eq("t1_words", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++) check_eq("t1_data", got[i][31:0], 32'(i + 1));
    last_mask();
    check_eq("t1_last", lm, 32'h8);
    if (got.size() == 4) check_eq("t1_consecutive", 32'(acc_cyc[3] - acc_cyc[0]), 32'd3);
    check_eq("t1_reads", 32'(reads), 32'd4);

    // Backpressure
    got.delete(); acc_cyc.delete(); base = reads; unstable = 0;
    m_ready = 1'b0; load(8);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (m_valid && (m_data !== 32'd1)) unstable++;
    end
    check_eq("t2_reads_stalled", 32'(reads - base), 32'd4);
    check_eq("t2_head_valid", 32'(m_valid), 32'd1);
    check_eq("t2_head_data", m_data, 32'd1);
    check_eq("t2_stable", 32'(unstable), 32'd0);
    m_ready = 1'b1;
    run(20);
    check_eq("t2_words", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size(); i++) check_eq("t2_data", got[i][31:0], 32'(i + 1));
    last_mask();
    check_eq("t2_last", lm, 32'h88);

    // Flush with a partial burst buffered
    got.delete(); acc_cyc.delete(); fd_cnt = 0;
    load(6);
    for (int i = 0; i < 30 && got.size() < 4; i++) cyc();
    m_ready = 1'b0;
    run(8);
    check_eq("t3_buffered_head", m_data, 32'd5);
    flush = 1'b1;
    cyc();
    m_ready = 1'b1;
    run(10);
    check_eq("t3_words", 32'(got.size()), 32'd6);
    last_mask();
    check_eq("t3_last", lm, 32'h28);
    check_eq("t3_flush_done_cnt", 32'(fd_cnt), 32'd1);
    if (got.size() == 6) check_eq("t3_flush_done_time", 32'(fd_cyc), 32'(acc_cyc[5] + 1));
    got.delete(); acc_cyc.delete();
    load(4);
    run(15);
    check_eq("t3_next_words", 32'(got.size()), 32'd4);
    last_mask();
    check_eq("t3_next_last", lm, 32'h8);

    // Enable drop with two reads outstanding
    got.delete(); acc_cyc.delete(); lat = 2; base = reads;
    load(4);
    for (int i = 0; i < 20 && reads < base + 1; i++) cyc();
    enable = 1'b0;
    run(10);
    check_eq("t4_reads", 32'(reads - base), 32'd2);
    check_eq("t4_words", 32'(got.size()), 32'd2);
    for (int i = 0; i < got.size(); i++) check_eq("t4_data", got[i][31:0], 32'(i + 1));
    check_eq("t4_busy", 32'(busy), 32'd0);
    fq.delete(); fifo_empty = 1'b1; lat = 1;
    cyc();

    // Stray data with nothing outstanding
    got.delete(); acc_cyc.delete();
    data_out_vld = 1'b1; data_out = 32'hdead_beef;
    run(5);
    check_eq("t5_rd_err", 32'(rd_err), 32'd1);
    check_eq("t5_no_output", 32'(got.size()), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    fd_cnt = 0; t = cyc_n;
    flush = 1'b1;
    run(3);
    check_eq("t5_idle_flush_cnt", 32'(fd_cnt), 32'd1);
    check_eq("t5_idle_flush_time", 32'(fd_cyc), 32'(t + 1));
    check_eq("t5_rd_err_sticky", 32'(rd_err), 32'd1);

    // Reset with three words buffered
    enable = 1'b1; m_ready = 1'b0;
    fq.push_back(32'ha1); fq.push_back(32'ha2); fq.push_back(32'ha3); fifo_empty = 1'b0;
    run(8);
    check_eq("t6_pre_valid", 32'(m_valid), 32'd1);
    check_eq("t6_pre_data", m_data, 32'ha1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(m_valid), 32'd0);
    check_eq("t6_rst_data", m_data, 32'd0);
    check_eq("t6_rst_last", 32'(m_last), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_rd_err", 32'(rd_err), 32'd0);
    check_eq("t6_rst_read_req", 32'(read_req), 32'd0);
    fq.delete(); pq.delete(); pdue.delete(); got.delete(); acc_cyc.delete();
    data_out_vld = 1'b0; fifo_empty = 1'b1;
    @(negedge rd_clk);
    rst_n = 1'b1; m_ready = 1'b1;
    load(4);
    run(15);
    check_eq("t6_words", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++) check_eq("t6_data", got[i][31:0], 32'(i + 1));
    last_mask();
    check_eq("t6_last", lm, 32'h8);

    check_eq("read_req_while_empty", 32'(rr_empty_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
